// File: rtl/squash_ctrl.sv
// squash_ctrl: picks trap-over-branch squash, hands one packet to the frontend, then holds the backend for a drain window.
// Optional SQUASH_CTRL_STAT_EN adds per-source squash counters; otherwise the stat ports read 0.
module squash_ctrl #(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_br_squash_vld,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_npc,
    input  logic            i_trap_vld,
    input  logic [XLEN-1:0] i_trap_target,
    output logic            o_squash_vld,
    input  logic            i_squash_rdy,
    output logic            o_squash_dueToBranch,
    output logic            o_squash_branch_taken,
    output logic [XLEN-1:0] o_squash_arch_pc,
    output logic            o_busy,
    output logic [31:0]     o_stat_br_cnt,
    output logic [31:0]     o_stat_trap_cnt
);
    localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            due_q, due_d;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hs;

    assign hs = (state_q == REQ) & i_squash_rdy;

    // Trap wins a same-cycle tie: it belongs to the older instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        due_d   = due_q;
        taken_d = taken_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (i_trap_vld) begin
                    state_d = REQ;
                    due_d   = 1'b0;
                    taken_d = 1'b0;
                    pc_d    = i_trap_target;
                end else if (i_br_squash_vld) begin
                    state_d = REQ;
                    due_d   = 1'b1;
                    taken_d = i_br_taken;
                    pc_d    = i_br_npc;
                end
            end
            REQ: begin
                if (i_squash_rdy) begin
                    state_d = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
                    cnt_d   = CNT_INIT;
                end
            end
            DRAIN: begin
                state_d = (cnt_q == '0) ? IDLE : DRAIN;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            due_q   <= 1'b0;
            taken_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            due_q   <= due_d;
            taken_q <= taken_d;
            pc_q    <= pc_d;
        end
    end

    assign o_squash_vld          = (state_q == REQ);
    assign o_busy                = (state_q != IDLE);
    assign o_squash_dueToBranch  = due_q;
    assign o_squash_branch_taken = taken_q;
    assign o_squash_arch_pc      = pc_q;

`ifdef SQUASH_CTRL_STAT_EN
    logic [31:0] br_cnt_q, br_cnt_d, trap_cnt_q, trap_cnt_d;

    always_comb begin
        br_cnt_d   = br_cnt_q + {31'd0, hs & due_q};
        trap_cnt_d = trap_cnt_q + {31'd0, hs & ~due_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q   <= '0;
            trap_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign o_stat_br_cnt   = br_cnt_q;
    assign o_stat_trap_cnt = trap_cnt_q;
`else
    logic unused_hs;
    assign unused_hs       = hs;
    assign o_stat_br_cnt   = '0;
    assign o_stat_trap_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Commit is blocked while busy, so a request here means an upstream bug; it is dropped.
    always @(posedge clk) begin
        if (rst && state_q != IDLE)
            assert (!(i_br_squash_vld || i_trap_vld))
            else $warning("squash_ctrl: request ignored while busy");
    end
`endif
endmodule

// File: doc/squash_ctrl.md
# squash_ctrl

Backend squash sequencer between ROB/commit and the frontend/rename. It accepts squash requests from two sources (mispredicted branch retirement, trap/exception at commit), picks one by fixed priority, presents a single squash packet (dueToBranch, branch_taken, arch_pc) to the frontend with a valid/ready handshake, then holds the backend blocked for a programmable drain window before releasing commit and rename.

## Interface
- XLEN, 64, width of arch_pc / target fields
- DRAIN_CYCLES, 2, cycles of DRAIN after handshake; 0 legal; counter width $clog2(DRAIN_CYCLES+1), min 1
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- i_br_squash_vld  in  1  mispredicted branch retired this cycle
- i_br_taken  in  1  branch actual direction
- i_br_npc  in  XLEN  correct next pc of the branch
- i_trap_vld  in  1  trap/xret redirect from commit this cycle
- i_trap_target  in  XLEN  redirect pc (tvec or epc)
- o_squash_vld  out  1  squash packet valid
- i_squash_rdy  in  1  frontend accepts packet
- o_squash_dueToBranch  out  1  1 = branch source, 0 = trap
- o_squash_branch_taken  out  1  copy of i_br_taken; 0 for trap
- o_squash_arch_pc  out  XLEN  redirect pc
- o_busy  out  1  state != IDLE; blocks commit and rename
- o_stat_br_cnt  out  32  branch squash count (see Configuration)
- o_stat_trap_cnt  out  32  trap squash count

## Operation
- States: IDLE, REQ, DRAIN.
- IDLE: if i_trap_vld or i_br_squash_vld, latch packet, go REQ. Trap beats branch when both valid same cycle (trap belongs to the older instruction); branch request dropped.
- Trap packet: dueToBranch=0, branch_taken=0, arch_pc=i_trap_target. Branch packet: dueToBranch=1, branch_taken=i_br_taken, arch_pc=i_br_npc.
- REQ: o_squash_vld=1; packet fields stable until handshake. On o_squash_vld & i_squash_rdy: go DRAIN with counter=DRAIN_CYCLES-1, or IDLE if DRAIN_CYCLES=0.
- DRAIN: counter decrements each cycle; at 0 go IDLE.
- Requests arriving while not IDLE are ignored (o_busy blocks commit, so none expected); simulation assertion flags any.
- Packet registers hold last value after return to IDLE; only o_squash_vld qualifies them.

## Timing
- Reset (rst=0, async): state IDLE, o_squash_vld=0, o_busy=0, o_squash_dueToBranch=0, o_squash_branch_taken=0, o_squash_arch_pc=0, counter=0, stat counters=0.
- Request sampled at edge of cycle T; o_squash_vld and o_busy high from T+1.
- Handshake at cycle H (first cycle with rdy=1 in REQ, H≥T+1); DRAIN occupies H+1..H+DRAIN_CYCLES; o_busy low from H+DRAIN_CYCLES+1. Minimum busy window = 1+DRAIN_CYCLES cycles.
- No combinational path from inputs to outputs; all outputs registered.
- i_squash_rdy ignored outside REQ.
- Reset mid-REQ or mid-DRAIN: immediate return to IDLE, pending packet lost.
- Back-to-back: a new request in the cycle o_busy falls is accepted (IDLE that cycle).

## Configuration
- SQUASH_CTRL_STAT_EN defined: o_stat_br_cnt / o_stat_trap_cnt increment by 1 on each REQ handshake of the respective source, wrap at 2^32, reset to 0.
- Not defined: counters not instantiated; both ports tied to 0. Ports always present.

## Test plan
- Branch only: i_br_squash_vld=1, i_br_taken=1, i_br_npc=0x8000_0040 at T, rdy=1 -> o_squash_vld at T+1 with dueToBranch=1, taken=1, pc=0x8000_0040; o_busy T+1..T+3 (DRAIN_CYCLES=2), low at T+4.
- Simultaneous: trap target 0x8000_0100 and branch npc 0x8000_0040 same cycle -> single packet dueToBranch=0, taken=0, pc=0x8000_0100; branch never emitted.
- Backpressure: rdy low 3 cycles after o_squash_vld -> packet fields constant all 4 cycles; DRAIN starts after the rdy=1 cycle.
- Request during DRAIN: branch pulse in DRAIN -> ignored, no second o_squash_vld, assertion fires.
- Async reset asserted mid-REQ -> o_squash_vld and o_busy drop without a clock edge; next request after release behaves as fresh.
- DRAIN_CYCLES=0 with SQUASH_CTRL_STAT_EN: 3 branch + 2 trap squashes -> busy exactly 1 cycle each with rdy=1; o_stat_br_cnt=3, o_stat_trap_cnt=2; without macro both read 0.
